// File: rtl/display_scanner.sv
// Six-digit seven-segment scanner: one shared active-low segment bus, per-digit
// active-low anodes, anti-ghost blanking, PWM brightness within each slot and blinking.
module display_scanner #(
    parameter int main_clock   = 10_000_000,
    parameter int digit_rate   = 1200,
    parameter int blank_cycles = 64,
    parameter int blink_hz     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] us,
    input  logic [7:0] ds,
    input  logic [7:0] um,
    input  logic [7:0] dm,
    input  logic [7:0] uh,
    input  logic [7:0] dh,
    input  logic [2:0] brightness,
    input  logic [5:0] blink_mask,
    output logic [7:0] seg,
    output logic [5:0] an,
    output logic [2:0] scan_idx,
    output logic       frame_start
);
    localparam int SLOT   = main_clock / digit_rate;
    localparam int ACTIVE = SLOT - blank_cycles;
    localparam int HALF   = main_clock / (2 * blink_hz);
    localparam int CW     = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int EW     = $clog2(SLOT + 1);
    localparam int PW     = $clog2(ACTIVE * 8 + 1);
    localparam int BW     = (HALF > 1) ? $clog2(HALF) : 1;

    generate
        if (blank_cycles >= SLOT) begin : g_bad_blank
            $error("display_scanner: blank_cycles must be smaller than main_clock/digit_rate");
        end
        // At least one blank cycle separates digits and gives the slot-start latch time to settle.
        if (blank_cycles < 1) begin : g_no_blank
            $error("display_scanner: blank_cycles must be at least 1");
        end
        if (HALF < 1) begin : g_bad_blink
            $error("display_scanner: blink_hz too high for main_clock");
        end
    endgenerate

    typedef enum logic [1:0] {S_BLANK, S_ON, S_OFF} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [EW-1:0] w_cnt_ext;
    logic [2:0]    r_idx, w_idx_nxt;
    logic          w_wrap, w_slot_start;
    logic [7:0]    r_pat, w_pat_in, w_pat;
    logic [PW-1:0] w_prod;
    logic [EW-1:0] w_on_cycles, w_on_end, r_on_end;
    logic          r_hide, w_hide_in, w_hide;
    logic [BW-1:0] r_bcnt;
    logic          r_phase;
    logic [7:0]    r_seg;
    logic [5:0]    r_an;
    logic          r_fs;

    assign w_wrap       = (r_cnt == CW'(SLOT - 1));
    assign w_slot_start = (r_cnt == '0);
    assign w_cnt_nxt    = w_wrap ? '0 : r_cnt + CW'(1);
    assign w_cnt_ext    = EW'(w_cnt_nxt);
    assign w_idx_nxt    = !w_wrap ? r_idx : (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;

    always_comb begin
        w_pat_in = 8'hFF;
        case (r_idx)
            3'd0:    w_pat_in = us;
            3'd1:    w_pat_in = ds;
            3'd2:    w_pat_in = um;
            3'd3:    w_pat_in = dm;
            3'd4:    w_pat_in = uh;
            3'd5:    w_pat_in = dh;
            default: w_pat_in = 8'hFF;
        endcase
    end

    // on_cycles = max(1, floor(ACTIVE*(brightness+1)/8)); ON ends at blank_cycles + on_cycles.
    assign w_prod      = PW'(ACTIVE) * (PW'(brightness) + PW'(1));
    assign w_on_cycles = (EW'(w_prod >> 3) == '0) ? EW'(1) : EW'(w_prod >> 3);
    assign w_on_end    = EW'(blank_cycles) + w_on_cycles;
    assign w_hide_in   = blink_mask[r_idx] & ~r_phase;

    // On the slot-start cycle the latches are still loading, so use their inputs directly.
    assign w_pat  = w_slot_start ? w_pat_in  : r_pat;
    assign w_hide = w_slot_start ? w_hide_in : r_hide;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BLANK: if (w_cnt_ext == EW'(blank_cycles)) w_state_nxt = S_ON;
            S_ON: begin
                if (w_wrap)                     w_state_nxt = S_BLANK;
                else if (w_cnt_ext == r_on_end) w_state_nxt = S_OFF;
            end
            S_OFF:   if (w_wrap) w_state_nxt = S_BLANK;
            default: w_state_nxt = S_BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_BLANK;
            r_cnt    <= '0;
            r_idx    <= 3'd0;
            r_pat    <= 8'hFF;
            r_on_end <= '0;
            r_hide   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            if (w_slot_start) begin
                r_pat    <= w_pat_in;
                r_on_end <= w_on_end;
                r_hide   <= w_hide_in;
            end
        end
    end

    // Free-running blink timebase; only sampled at slot start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bcnt  <= '0;
            r_phase <= 1'b1;
        end else if (r_bcnt == BW'(HALF - 1)) begin
            r_bcnt  <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_bcnt <= r_bcnt + BW'(1);
        end
    end

    // Outputs are registered from the next state so an/seg line up with r_cnt/r_idx.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seg <= 8'hFF;
            r_an  <= 6'h3F;
            r_fs  <= 1'b0;
        end else begin
            r_fs <= w_wrap && (w_idx_nxt == 3'd0);
            if (w_state_nxt == S_ON && !w_hide) begin
                r_an  <= ~(6'd1 << r_idx);
                r_seg <= w_pat;
            end else begin
                r_an  <= 6'h3F;
                r_seg <= 8'hFF;
            end
        end
    end

    assign seg         = r_seg;
    assign an          = r_an;
    assign scan_idx    = r_idx;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: per-cycle expectations from a slot-level
// reference model are queued by the stimulus and popped by a negedge monitor.
module tb_display_scanner;
    localparam int MAIN   = 1200;
    localparam int RATE   = 100;
    localparam int BLANK  = 2;
    localparam int BHZ    = 10;
    localparam int SLOT   = MAIN / RATE;
    localparam int ACTIVE = SLOT - BLANK;
    localparam int HALF   = MAIN / (2 * BHZ);

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] us, ds, um, dm, uh, dh;
    logic [2:0] brightness;
    logic [5:0] blink_mask;
    logic [7:0] seg;
    logic [5:0] an;
    logic [2:0] scan_idx;
    logic       frame_start;

    display_scanner #(
        .main_clock(MAIN), .digit_rate(RATE), .blank_cycles(BLANK), .blink_hz(BHZ)
    ) dut (
        .clk(clk), .rst(rst),
        .us(us), .ds(ds), .um(um), .dm(dm), .uh(uh), .dh(dh),
        .brightness(brightness), .blink_mask(blink_mask),
        .seg(seg), .an(an), .scan_idx(scan_idx), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] seg;
        logic [5:0] an;
        logic [2:0] idx;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int errors  = 0;

    // Model state: n is the index of the next cycle since reset release.
    int         n = 0;
    logic [7:0] m_pat  = 8'hFF;
    int         m_on   = 1;
    bit         m_hide = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic push_cycle();
        exp_t       e;
        int         c, idx;
        logic [7:0] pats[6];
        if (!rst) begin
            e.seg = 8'hFF; e.an = 6'h3F; e.idx = 3'd0; e.fs = 1'b0;
            q.push_back(e);
            n = 0;
            return;
        end
        c   = n % SLOT;
        idx = (n / SLOT) % 6;
        pats = '{us, ds, um, dm, uh, dh};
        if (c == 0) begin
            m_pat  = pats[idx];
            m_on   = (ACTIVE * (int'(brightness) + 1)) / 8;
            if (m_on < 1) m_on = 1;
            m_hide = blink_mask[idx] && (((n / HALF) % 2) == 1);
        end
        e.idx = 3'(idx);
        e.fs  = (c == 0 && idx == 0 && n != 0);
        if (c >= BLANK && c < BLANK + m_on && !m_hide) begin
            e.an  = ~(6'd1 << idx);
            e.seg = m_pat;
        end else begin
            e.an  = 6'h3F;
            e.seg = 8'hFF;
        end
        q.push_back(e);
        n++;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int k);
        repeat (k) begin
            step();
            push_cycle();
        end
    endtask

    task automatic run_to(input int c, input int idx);
        while (!((n % SLOT) == c && ((n / SLOT) % 6) == idx)) begin
            step();
            push_cycle();
        end
    endtask

    // Monitor: compares every cycle, plus overlap and inter-digit gap properties.
    exp_t       m_e;
    int         high_run = 0;
    bit         had_low  = 1'b0;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            chk("seg", 32'(seg), 32'(m_e.seg));
            chk("an", 32'(an), 32'(m_e.an));
            chk("scan_idx", 32'(scan_idx), 32'(m_e.idx));
            chk("frame_start", 32'(frame_start), 32'(m_e.fs));
        end
        chk("an_onehot", 32'($countones(~an) <= 1), 32'(1));
        if (an == 6'h3F) begin
            high_run++;
        end else begin
            if (had_low) chk("digit_gap", 32'(high_run == 0 || high_run >= BLANK), 32'(1));
            high_run = 0;
            had_low  = 1'b1;
        end
    end

    initial begin
        us = 8'hC0; ds = 8'hF9; um = 8'hA4; dm = 8'hB0; uh = 8'h99; dh = 8'h92;
        brightness = 3'd7; blink_mask = 6'd0; rst = 1'b0;
        run(3);
        step(); rst = 1'b1; push_cycle();
        run(2 * 6 * SLOT - 1);

        brightness = 3'd3; run(6 * SLOT);
        brightness = 3'd0; run(6 * SLOT);
        run_to(5, 2);
        step(); brightness = 3'd7; push_cycle();
        run(2 * SLOT);

        blink_mask = 6'b000011; run(300);
        blink_mask = 6'd0;

        run_to(5, 0);
        step(); us = 8'hF9; push_cycle();
        run(7 * SLOT);

        repeat (800) begin
            step();
            case ($urandom_range(0, 31))
                0: us = 8'($urandom);
                1: ds = 8'($urandom);
                2: um = 8'($urandom);
                3: dm = 8'($urandom);
                4: uh = 8'($urandom);
                5: dh = 8'($urandom);
                6, 7: brightness = 3'($urandom);
                8: blink_mask = 6'($urandom);
                default: ;
            endcase
            push_cycle();
        end

        brightness = 3'd7; blink_mask = 6'd0;
        run(6 * SLOT);
        run_to(4, 3);
        step();
        chk("pre_reset_an", 32'(an), 32'(6'b110111));
        rst = 1'b0;
        #1;
        chk("async_an", 32'(an), 32'(6'h3F));
        chk("async_seg", 32'(seg), 32'(8'hFF));
        chk("async_idx", 32'(scan_idx), 32'(0));
        push_cycle();
        run(2);
        step(); rst = 1'b1; push_cycle();
        run(7 * SLOT);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
